alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU interface: accepts 16-bit commands over valid/ready and decodes them.

---
 rtl/alu_cmd_sequencer_pkg.sv | 51 +++++
 rtl/alu_cmd_sequencer_regfile.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: opcodes, command field positions, FSM states and decode helpers
package alu_cmd_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_INC = 4'b1101;
  localparam logic [3:0] OP_DEC = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_RD  = 4'b0001;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 10;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Every ALU opcode has bit 2 set; the sequencer-local and illegal codes all have it clear.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return !op[2] && (op[3] || op[1]);
  endfunction

  function automatic logic [3:0] cmd_op(input logic [15:0] c);
    return c[OP_LSB +: 4];
  endfunction

  function automatic logic [1:0] cmd_rd(input logic [15:0] c);
    return c[RD_LSB +: 2];
  endfunction

  function automatic logic [1:0] cmd_ra(input logic [15:0] c);
    return c[RA_LSB +: 2];
  endfunction

  function automatic logic [1:0] cmd_rb(input logic [15:0] c);
    return c[RB_LSB +: 2];
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_regfile.sv
// alu_cmd_regfile: 4x8 register file, two combinational read ports, one synchronous write port
module alu_cmd_regfile #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [7:0] wdata
);

  logic [7:0] regs [4];

  assign rdata_a = regs[ra];
  assign rdata_b = regs[rb];

  // Register storage: every entry returns to REG_INIT on reset, one write per cycle otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
    end else if (we) begin
      regs[wa] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts 16-bit commands, drives an 8-bit combinational ALU, writes back and responds
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] REG_INIT      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        alu_enable,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_cout,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] rd_q;
  logic [7:0] rdata_a, rdata_b;
  logic [3:0] op;
  logic [7:0] imm;
  logic       accept, last_issue;
  logic       we;
  logic [1:0] wa;
  logic [7:0] wdata;

  assign op         = cmd_op(cmd_data);
  assign imm        = cmd_data[7:0];
  assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign last_issue = (state == ST_ISSUE) && (cnt == 4'd0);

  // Write port: LDI writes at accept, ALU ops write their result on the last ISSUE cycle
  always_comb begin
    we    = (accept && op == OP_LDI) || last_issue;
    wa    = accept ? cmd_rd(cmd_data) : rd_q;
    wdata = accept ? imm : alu_out;
  end

  alu_cmd_regfile #(.REG_INIT(REG_INIT)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (cmd_ra(cmd_data)),
    .rb      (cmd_rb(cmd_data)),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (we),
    .wa      (wa),
    .wdata   (wdata)
  );

  // Sequencer FSM with registered handshake, ALU drive and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      rd_q       <= 2'd0;
      cmd_ready  <= 1'b0;
      alu_enable <= 1'b0;
      alu_A      <= 8'h00;
      alu_B      <= 8'h00;
      alu_opcode <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready  <= 1'b0;
            alu_opcode <= op;
            alu_A      <= rdata_a;
            alu_B      <= rdata_b;
            rd_q       <= cmd_rd(cmd_data);
            cnt        <= CNT_INIT;
            rsp_cout   <= 1'b0;
            rsp_err    <= is_illegal(op);
            if (is_alu_op(op)) begin
              alu_enable <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= (op == OP_LDI) ? imm : (op == OP_RD) ? rdata_a : 8'h00;
              state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt == 4'd0) begin
            alu_enable <= 1'b0;
            rsp_data   <= alu_out;
            rsp_cout   <= alu_cout;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and random commands checked against a register-file reference model
module tb_alu_cmd_sequencer;

  localparam int         S    = 3;
  localparam logic [7:0] INIT = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = 16'h0;
  logic        alu_enable;
  logic [7:0]  alu_A, alu_B;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_cout;
  logic        rsp_err;

  int checks = 0;
  int passed = 0;
  logic [7:0] mreg [4];

  alu_cmd_sequencer #(.SETTLE_CYCLES(S), .REG_INIT(INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .alu_enable (alu_enable),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Combinational 8-bit ALU the sequencer talks to
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b1111: return {1'b0, a} + {1'b0, b};
      4'b1110: return {a < b, 8'(a - b)};
      4'b1101: return {1'b0, a} + 9'd1;
      4'b1100: return {a == 8'h00, 8'(a - 8'd1)};
      4'b0111: return {1'b0, a & b};
      4'b0110: return {1'b0, a | b};
      4'b0101: return {1'b0, a ^ b};
      4'b0100: return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  always_comb {alu_cout, alu_out} = alu_fn(alu_opcode, alu_A, alu_B);

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'b0000, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 6'b000000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: derive response and register update from the command's meaning
  task automatic predict(input logic [15:0] c, output logic [7:0] d, output logic co, output logic err,
                         output int lat, output int en);
    logic [3:0] op = c[15:12];
    logic [7:0] a = mreg[c[9:8]];
    logic [7:0] b = mreg[c[7:6]];
    logic       alu_op = op inside {4'hF, 4'hE, 4'hD, 4'hC, 4'h7, 4'h6, 4'h5, 4'h4};
    d = 8'h00; co = 1'b0; err = 1'b0;
    if (alu_op) {co, d} = alu_fn(op, a, b);
    else if (op == 4'h0) d = c[7:0];
    else if (op == 4'h1) d = a;
    else err = 1'b1;
    if (alu_op || op == 4'h0) mreg[c[11:10]] = d;
    lat = alu_op ? S + 1 : 1;
    en  = alu_op ? S : 0;
  endtask

  task automatic run(input logic [15:0] c, input int hold, input string tag);
    logic [7:0] ed;
    logic       ec, ee, busy_ok, stable_ok;
    int         el, een, lat, en;
    predict(c, ed, ec, ee, el, een);
    @(negedge clk);
    cmd_data  = c;
    cmd_valid = 1'b1;
    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".ready"}, cmd_ready, 1);
    lat = 0; en = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (alu_enable) en++;
      if (cmd_ready !== 1'b0) busy_ok = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 40);
    chk({tag, ".lat"}, lat, el);
    chk({tag, ".en_cycles"}, en, een);
    chk({tag, ".data"}, rsp_data, ed);
    chk({tag, ".cout"}, rsp_cout, ec);
    chk({tag, ".err"}, rsp_err, ee);
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_cout !== ec || rsp_err !== ee || cmd_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    chk({tag, ".busy_stable"}, {busy_ok, stable_ok}, 2'b11);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mreg[i] = INIT;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", {cmd_ready, alu_enable, alu_A, alu_B, alu_opcode, rsp_valid, rsp_data, rsp_cout, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.ready_after_release", cmd_ready, 1);

    run(ldi(2'd0, 8'hF0), 0, "t1.ldi0");
    run(ldi(2'd1, 8'h20), 0, "t1.ldi1");
    run(cmd(4'hF, 2'd2, 2'd0, 2'd1), 0, "t1.add");
    chk("t1.add_value", mreg[2], 8'h10);
    run(cmd(4'h1, 2'd0, 2'd2, 2'd0), 1, "t1.rd");

    run(ldi(2'd0, 8'hFF), 0, "t2.ldi0");
    run(cmd(4'hD, 2'd1, 2'd0, 2'd0), 0, "t2.inc");
    run(ldi(2'd2, 8'hAA), 0, "t2.ldi2");
    run(cmd(4'h5, 2'd3, 2'd0, 2'd2), 0, "t2.xor");
    chk("t2.xor_value", mreg[3], 8'h55);

    run(cmd(4'hF, 2'd3, 2'd1, 2'd2), 5, "t3.hold");

    run(ldi(2'd1, 8'h33), 0, "t4.ldi1");
    run(cmd(4'b0010, 2'd1, 2'd1, 2'd1), 2, "t4.illegal");
    run(cmd(4'h1, 2'd0, 2'd1, 2'd0), 0, "t4.rd1");

    @(negedge clk);
    cmd_data  = cmd(4'hF, 2'd3, 2'd0, 2'd1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5.issue_en", {alu_enable, cmd_ready}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5.reset_outputs", {cmd_ready, alu_enable, alu_A, alu_B, alu_opcode, rsp_valid, rsp_data, rsp_cout, rsp_err}, 0);
    for (int i = 0; i < 4; i++) mreg[i] = INIT;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.ready_after_release", cmd_ready, 1);
    run(cmd(4'h1, 2'd0, 2'd3, 2'd0), 0, "t5.rd3");
    run(cmd(4'hF, 2'd0, 2'd0, 2'd3), 0, "t5.add");

    run(ldi(2'd1, 8'h07), 0, "t6.ldi1");
    run(cmd(4'hE, 2'd1, 2'd1, 2'd1), 0, "t6.sub");
    run(cmd(4'h1, 2'd0, 2'd1, 2'd0), 0, "t6.rd1");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] c;
      c = 16'($urandom);
      if ($urandom_range(0, 2) == 0) c[15:12] = 4'h0;
      run(c, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 4; i++) run(cmd(4'h1, 2'd0, 2'(i), 2'd0), 0, $sformatf("final.rd%0d", i));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
